uart_tx_arbiter: RTL

Shares the single UART transmitter between two requesters: the main controller (configuration/acknowledge packets) and the CPU-side TX FIFO. It selects one source per packet, sequences the start/done handshake with the transmitter, and aborts a transfer if the transmitter never reports completion. It sits between the main controller, the TX FIFO read port and the transmitter input.

---
 rtl/UART_pkg.sv | 19 +
 rtl/tx_arb_timer.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/UART_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Optional build macro used by the arbiter: UART_TX_FAIRNESS_EN.
package UART_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } tx_arb_fsm_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_CTRL = 2'b01,
        SRC_CPU  = 2'b10
    } tx_src_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/tx_arb_timer.sv
// Saturating cycle counter that watches for a missing transmitter completion.
// The expired flag stays high while the count sits at LIMIT.
module tx_arb_timer #(
    parameter int LIMIT = 16,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT_C)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT_C);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the main controller and the CPU TX FIFO.
// Define UART_TX_FAIRNESS_EN to force a CPU slot after MAX_CTRL_BURST controller grants.
module uart_tx_arbiter
    import UART_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int MAX_CTRL_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ctrl_req_i,
    input  logic [DATA_WIDTH-1:0] ctrl_data_i,
    output logic                  ctrl_gnt_o,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_read_o,
    input  logic                  cfg_mode_i,
    output logic                  tx_start_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    input  logic                  tx_done_i,
    output logic                  busy_o,
    output logic [1:0]            active_src_o,
    output logic                  timeout_o
);

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_START     = START;
    localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       in_idle;
    logic       ctrl_elig;
    logic       cpu_elig;
    logic       force_cpu;
    logic       grant_ctrl;
    logic       grant_cpu;
    logic       timer_expired;
    logic       xfer_end;

    // Grants are combinational strobes, so hold them off while reset is applied.
    assign in_idle   = (state == ST_IDLE) && !rst_i;
    assign ctrl_elig = ctrl_req_i;
    assign cpu_elig  = !fifo_empty_i && !cfg_mode_i;

`ifdef UART_TX_FAIRNESS_EN
    localparam int BW = $clog2(MAX_CTRL_BURST + 1);

    logic [BW-1:0] burst_cnt;

    assign force_cpu = (burst_cnt == BW'(MAX_CTRL_BURST));

    // Only controller wins that actually starved the CPU count toward a forced slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            burst_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (grant_cpu || !cpu_elig) begin
                burst_cnt <= '0;
            end else if (grant_ctrl) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_burst;

    assign force_cpu    = 1'b0;
    assign unused_burst = (MAX_CTRL_BURST > 0);
`endif

    assign grant_ctrl = in_idle && ctrl_elig && !(force_cpu && cpu_elig);
    assign grant_cpu  = in_idle && cpu_elig && (!ctrl_elig || force_cpu);
    assign xfer_end   = (state == ST_WAIT_DONE) && (tx_done_i || timer_expired);

    tx_arb_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (state != ST_WAIT_DONE),
        .enable  (state == ST_WAIT_DONE),
        .expired (timer_expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (grant_ctrl || grant_cpu) state_nxt = ST_START;
            ST_START:     state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (tx_done_i || timer_expired) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            tx_data_o    <= '0;
            active_src_o <= SRC_NONE;
        end else begin
            state <= state_nxt;
            if (grant_ctrl) begin
                tx_data_o    <= ctrl_data_i;
                active_src_o <= SRC_CTRL;
            end else if (grant_cpu) begin
                tx_data_o    <= fifo_data_i;
                active_src_o <= SRC_CPU;
            end else if (xfer_end) begin
                active_src_o <= SRC_NONE;
            end
        end
    end

    assign ctrl_gnt_o  = grant_ctrl;
    assign fifo_read_o = grant_cpu;
    assign tx_start_o  = (state == ST_START);
    assign busy_o      = (state != ST_IDLE);
    // A completion arriving on the expiry cycle takes precedence over the abort.
    assign timeout_o   = (state == ST_WAIT_DONE) && timer_expired && !tx_done_i;

endmodule
